// File: rtl/psg_audio_pkg.sv
// Shared PSG audio types and constants: default channel width, sample/frame
// types and the sample-rate helper for the I2S divider.
package psg_audio_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [2*SAMPLE_W-1:0]      frame_t;

    // Output sample rate in Hz for a given BCK half-period in 27 MHz clocks.
    function automatic int unsigned fs_hz(input int unsigned div_half);
        return 27_000_000 / (4 * div_half * SAMPLE_W);
    endfunction

endpackage

// File: rtl/psg_i2s_clkgen.sv
// BCK generator for the PSG I2S transmitter: divides clk_27m into the bit
// clock and tracks the bit position within the stereo frame.
module psg_i2s_clkgen
    import psg_audio_pkg::*;
#(
    parameter int unsigned DIV_HALF   = 8,
    parameter int unsigned FRAME_BITS = 2 * SAMPLE_W,
    localparam int unsigned DIV_W     = $clog2(DIV_HALF),
    localparam int unsigned BIT_W     = $clog2(FRAME_BITS)
) (
    input  logic             clk_27m,
    input  logic             reset,
    output logic             i2s_bck,
    output logic             bck_fall,
    output logic             frame_load,
    output logic [BIT_W-1:0] bit_cnt
);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap       = (div_cnt == DIV_W'(DIV_HALF - 1));
    assign bck_fall   = wrap & i2s_bck;
    assign frame_load = bck_fall & (bit_cnt == BIT_W'(FRAME_BITS - 1));

    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            i2s_bck <= 1'b0;
            bit_cnt <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
            i2s_bck <= ~i2s_bck;
            if (i2s_bck) begin
                bit_cnt <= frame_load ? '0 : bit_cnt + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/psg_i2s_tx.sv
// PSG stereo I2S transmitter: valid/ready sample intake, double buffering and
// serialisation to BCK/WS/SDATA. Define PSG_I2S_PT8211_EN for PT8211 framing.
module psg_i2s_tx #(
    parameter int unsigned SAMPLE_W = psg_audio_pkg::SAMPLE_W,
    parameter int unsigned DIV_HALF = 8
) (
    input  logic                clk_27m,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                frame_start,
    output logic                underrun,
    output logic                i2s_bck,
    output logic                i2s_ws,
    output logic                i2s_sdata
);

    localparam int unsigned FRAME_BITS = 2 * SAMPLE_W;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    logic                  bck_fall;
    logic                  frame_load;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_nxt;
    logic                  pending;
    logic                  accept;
    logic [FRAME_BITS-1:0] hold_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] last_word;
    logic [FRAME_BITS-1:0] load_word;
    logic [FRAME_BITS-1:0] cur_word;
    logic [FRAME_BITS-1:0] next_shift;

    psg_i2s_clkgen #(
        .DIV_HALF   (DIV_HALF),
        .FRAME_BITS (FRAME_BITS)
    ) u_clkgen (
        .clk_27m    (clk_27m),
        .reset      (reset),
        .i2s_bck    (i2s_bck),
        .bck_fall   (bck_fall),
        .frame_load (frame_load),
        .bit_cnt    (bit_cnt)
    );

    assign in_ready    = ~pending;
    assign accept      = in_valid & ~pending;
    assign frame_start = frame_load;
    assign bit_nxt     = frame_load ? '0 : bit_cnt + 1'b1;
    assign load_word   = pending ? hold_reg
                       : (accept ? {in_left, in_right} : last_word);

    // The shift register rotates rather than shifts, so after a full frame of
    // rotations it holds the word again and an underrun can simply reuse it.
`ifdef PSG_I2S_PT8211_EN
    localparam logic WS_LEFT = 1'b1;
    assign cur_word   = frame_load ? load_word : shift_reg;
    assign last_word  = shift_reg;
    assign next_shift = {cur_word[FRAME_BITS-2:0], cur_word[FRAME_BITS-1]};
`else
    // One-BCK delay: the load cycle still emits the previous right LSB, which
    // leaves the register one rotation short of the original word.
    localparam logic WS_LEFT = 1'b0;
    assign cur_word   = shift_reg;
    assign last_word  = {shift_reg[FRAME_BITS-2:0], shift_reg[FRAME_BITS-1]};
    assign next_shift = frame_load ? load_word
                      : {shift_reg[FRAME_BITS-2:0], shift_reg[FRAME_BITS-1]};
`endif

    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) begin
            pending   <= 1'b0;
            hold_reg  <= '0;
            shift_reg <= '0;
            underrun  <= 1'b0;
            i2s_ws    <= WS_LEFT;
            i2s_sdata <= 1'b0;
        end else begin
            if (frame_load) begin
                if (pending) begin
                    pending <= 1'b0;
                end else if (!accept) begin
                    underrun <= 1'b1;
                end
            end else if (accept) begin
                hold_reg <= {in_left, in_right};
                pending  <= 1'b1;
            end

            if (bck_fall) begin
                i2s_ws    <= (bit_nxt < BIT_W'(SAMPLE_W)) ? WS_LEFT : ~WS_LEFT;
                i2s_sdata <= cur_word[FRAME_BITS-1];
                shift_reg <= next_shift;
            end
        end
    end

endmodule

// File: tb/tb_psg_i2s_tx.sv
// Scoreboard bench for psg_i2s_tx: expected frame words are queued by the
// stimulus and matched by a monitor that deserialises the I2S stream.
module tb_psg_i2s_tx;
    import psg_audio_pkg::*;

    localparam int unsigned DIV_HALF   = 8;
    localparam int unsigned BCK_CLKS   = 2 * DIV_HALF;
    localparam int unsigned FRAME_CLKS = 512;
    localparam int unsigned WAIT_MAX   = 600;
`ifdef PSG_I2S_PT8211_EN
    localparam logic   WS_LEFT    = 1'b1;
    localparam frame_t WS_PATTERN = 32'hFFFF_0000;
`else
    localparam logic   WS_LEFT    = 1'b0;
    localparam frame_t WS_PATTERN = 32'h0000_FFFF;
`endif

    logic    clk_27m = 1'b0;
    logic    reset   = 1'b1;
    sample_t in_left;
    sample_t in_right;
    logic    in_valid;
    logic    in_ready, frame_start, underrun, i2s_bck, i2s_ws, i2s_sdata;

    int unsigned cyc = 0;
    int unsigned last_fs;
    int unsigned n_checks;
    int unsigned n_pass;
    frame_t      exp_q[$];
    frame_t      s3_vec[4];

    psg_i2s_tx #(
        .SAMPLE_W (16),
        .DIV_HALF (DIV_HALF)
    ) dut (
        .clk_27m     (clk_27m),
        .reset       (reset),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_start (frame_start),
        .underrun    (underrun),
        .i2s_bck     (i2s_bck),
        .i2s_ws      (i2s_ws),
        .i2s_sdata   (i2s_sdata)
    );

    always #5 clk_27m = ~clk_27m;
    always @(posedge clk_27m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    task automatic score_frame(input frame_t got);
        frame_t want;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL frame_unexpected: got %h, expected none queued", got);
        end else begin
            want = exp_q.pop_front();
            check("frame_data", got, want);
        end
    endtask

    task automatic wait_fs(input string tag);
        int unsigned k;
        k = 0;
        do begin
            @(negedge clk_27m);
            k++;
        end while (!frame_start && k < WAIT_MAX);
        if (!frame_start) begin
            n_checks++;
            $display("FAIL %s_timeout: got no frame_start, expected one within %0d clks", tag, WAIT_MAX);
        end
    endtask

    // Drains the scoreboard, asserts reset between clock edges so the async
    // clear is visible without a clock, then releases on a falling edge.
    task automatic do_reset(input string tag);
        repeat (16) @(negedge clk_27m);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        #1 check({tag, "_reset_outputs"},
                 {i2s_bck, i2s_ws, i2s_sdata, frame_start, underrun, in_ready},
                 {1'b0, WS_LEFT, 1'b0, 1'b0, 1'b0, 1'b1});
        repeat (3) @(negedge clk_27m);
        reset   = 1'b0;
        last_fs = cyc - 1;  // first load is 511 edges after release: period 512
    endtask

    task automatic offer_pair(input string tag, input frame_t w);
        check({tag, "_ready_before_accept"}, in_ready, 1);
        in_left  = w[31:16];
        in_right = w[15:0];
        in_valid = 1'b1;
        @(negedge clk_27m);
        in_valid = 1'b0;
        check({tag, "_ready_low_while_pending"}, in_ready, 0);
    endtask

    initial begin : monitor
        logic        bck_q, ws_q;
        bit          locked, started, pre_one, have_rise;
        int unsigned bitn, last_rise;
        frame_t      data_sr, ws_sr;
        bck_q = 1'b0; ws_q = WS_LEFT; locked = 0; started = 0; pre_one = 0;
        have_rise = 0; bitn = 0; last_rise = 0; data_sr = '0; ws_sr = '0;
        forever begin
            @(negedge clk_27m);
            if (reset) begin
                bck_q = 1'b0; ws_q = WS_LEFT; locked = 0; started = 0;
                pre_one = 0; have_rise = 0; bitn = 0;
            end else begin
                if (frame_start) begin
                    check("frame_period", cyc - last_fs, FRAME_CLKS);
                    last_fs = cyc;
                end
                if (i2s_bck && !bck_q) begin
                    if (have_rise) check("bck_period", cyc - last_rise, BCK_CLKS);
                    have_rise = 1;
                    last_rise = cyc;
                    if (!locked && ws_q != WS_LEFT && i2s_ws == WS_LEFT) begin
                        locked = 1;
                        bitn   = 0;
                        check("pre_load_sdata_zero", pre_one, 0);
                    end else if (locked) begin
                        bitn = (bitn + 1) % 32;
                    end
                    if (!locked) begin
                        pre_one = pre_one | i2s_sdata;
                    end else begin
                        data_sr = {data_sr[30:0], i2s_sdata};
                        ws_sr   = {ws_sr[30:0], i2s_ws};
                        if (bitn == 31) check("ws_frame", ws_sr, WS_PATTERN);
`ifdef PSG_I2S_PT8211_EN
                        if (bitn == 31) score_frame(data_sr);
`else
                        if (bitn == 0) begin
                            if (started) score_frame(data_sr);
                            started = 1;
                        end
`endif
                    end
                    ws_q = i2s_ws;
                end
                bck_q = i2s_bck;
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        n_checks = 0; n_pass = 0; last_fs = 0;
        in_valid = 1'b0; in_left = '0; in_right = '0;
        s3_vec = '{32'h8001_7FFE, 32'hFFFF_0000, 32'h0000_FFFF, 32'h1234_ABCD};
        $display("psg_i2s_tx bench, fs = %0d Hz", fs_hz(DIV_HALF));

        // Idle: zeros repeat, underrun after the first load
        do_reset("s1");
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        wait_fs("s1_l1");
        check("s1_underrun_before_load", underrun, 0);
        @(negedge clk_27m);
        check("s1_underrun_after_load", underrun, 1);
        check("s1_ready_idle", in_ready, 1);
        wait_fs("s1_l2");
        wait_fs("s1_l3");

        // One pair then stop: it repeats and underrun sets on the second load
        do_reset("s2");
        exp_q.push_back(32'hA5C3_0F01); exp_q.push_back(32'hA5C3_0F01);
        offer_pair("s2", 32'hA5C3_0F01);
        wait_fs("s2_l1");
        check("s2_ready_held_to_load", in_ready, 0);
        @(negedge clk_27m);
        check("s2_ready_after_load", in_ready, 1);
        check("s2_no_underrun_first_load", underrun, 0);
        wait_fs("s2_l2");
        @(negedge clk_27m);
        check("s2_underrun_second_load", underrun, 1);
        check("s2_ready_stays_high", in_ready, 1);
        wait_fs("s2_l3");

        // Continuous in_valid: one accept per frame, never an underrun
        do_reset("s3");
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int unsigned k;
                    frame_t      w;
                    w        = s3_vec[i];
                    in_left  = w[31:16];
                    in_right = w[15:0];
                    in_valid = 1'b1;
                    k = 0;
                    while (!in_ready && k < WAIT_MAX) begin
                        @(negedge clk_27m);
                        k++;
                    end
                    if (!in_ready) begin
                        n_checks++;
                        $display("FAIL s3_accept_timeout: got in_ready=0, expected 1 within %0d clks", WAIT_MAX);
                    end
                    exp_q.push_back(w);
                    @(negedge clk_27m);
                    check("s3_ready_low_after_accept", in_ready, 0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) wait_fs("s3");
            end
        join
        check("s3_no_underrun", underrun, 0);

        // Bypass: a pair accepted on the load cycle goes out in that frame
        do_reset("s4");
        exp_q.push_back(32'h8000_7FFF); exp_q.push_back(32'h8000_7FFF);
        wait_fs("s4_l1");
        check("s4_ready_on_load", in_ready, 1);
        in_left  = 16'h8000;
        in_right = 16'h7FFF;
        in_valid = 1'b1;
        @(negedge clk_27m);
        in_valid = 1'b0;
        check("s4_bypass_no_underrun", underrun, 0);
        check("s4_bypass_not_pending", in_ready, 1);
        wait_fs("s4_l2");
        @(negedge clk_27m);
        check("s4_underrun_second_load", underrun, 1);
        wait_fs("s4_l3");

        // Reset at bit_cnt=20 of the first frame, then restart with a new pair
        do_reset("s5");
        wait_fs("s5_l1");
        @(negedge clk_27m);
        check("s5_underrun_before_reset", underrun, 1);
        repeat (320 - 1 - 16) @(negedge clk_27m);
        do_reset("s5_midframe");
        exp_q.push_back(32'h0F0F_F0F0); exp_q.push_back(32'h0F0F_F0F0);
        offer_pair("s5", 32'h0F0F_F0F0);
        wait_fs("s5_r1");
        check("s5_underrun_cleared", underrun, 0);
        wait_fs("s5_r2");
        wait_fs("s5_r3");

        do_reset("final");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
